prbs_checker_parallel_fab: RTL and testbench

Parallel PRBS7 checker (x^7 + x^6 + 1) that sits directly downstream of the fabric PRBS generator, after the IOD transmit/receive loopback. It consumes one NBITS-wide word per valid cycle and self-synchronises to the incoming stream. Once locked, it checks each word against a locally predicted reference and counts bit errors for SmartDebug readout.

---
 rtl/prbs_checker_parallel_fab.sv | 187 ++++++++++++++++++
 tb/tb_prbs_checker_parallel_fab.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker_parallel_fab.sv
`timescale 1ns/1ps
// Self-synchronising parallel PRBS7 (x^7 + x^6 + 1) checker with a saturating bit-error counter.
// Define PRBS_CHK_BITREV_EN to bit-reverse data_i (bit 0 first on the wire) before checking.
module prbs_checker_parallel_fab #(
    parameter int NBITS       = 8,
    parameter int LOCK_CNT    = 16,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    input  logic                 chk_en_i,
    input  logic                 clear_i,
    input  logic                 data_valid_i,
    input  logic [NBITS-1:0]     data_i,
    output logic                 lock_o,
    output logic                 err_o,
    output logic                 err_sticky_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int MCW = $clog2(LOCK_CNT + 1);
    localparam int BCW = $clog2(LOSS_THRESH + 1);
    localparam int PCW = $clog2(NBITS + 1);
    localparam int SW  = ((ERR_CNT_W > PCW) ? ERR_CNT_W : PCW) + 1;
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_e;

    function automatic logic [NBITS-1:0] prbsPredict(input logic [NBITS-1:0] w);
        logic [NBITS+6:0] s;
        s = '0;
        s[NBITS+6:NBITS] = w[6:0];
        for (int i = NBITS - 1; i >= 0; i--) begin
            s[i] = s[i+7] ^ s[i+6];
        end
        return s[NBITS-1:0];
    endfunction

    function automatic logic [PCW-1:0] popCount(input logic [NBITS-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < NBITS; i++) begin
            c = c + PCW'(v[i]);
        end
        return c;
    endfunction

    state_e                 state_q, state_d;
    logic [NBITS-1:0]       prev_q, prev_d;
    logic [NBITS-1:0]       ref_q, ref_d;
    logic                   seeded_q, seeded_d;
    logic [MCW-1:0]         match_q, match_d;
    logic [BCW-1:0]         bad_q, bad_d;
    logic                   err_q, err_d;
    logic                   sticky_q, sticky_d;
    logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;

    logic [NBITS-1:0]       dataW;
    logic [NBITS-1:0]       diff;
    logic [PCW-1:0]         errBits;
    logic [SW-1:0]          sumW;
    logic                   wordBad;
    logic                   searchMatch;

`ifdef PRBS_CHK_BITREV_EN
    always_comb begin
        dataW = '0;
        for (int i = 0; i < NBITS; i++) begin
            dataW[i] = data_i[NBITS-1-i];
        end
    end
`else
    assign dataW = data_i;
`endif

    assign diff        = dataW ^ ref_q;
    assign errBits     = popCount(diff);
    assign wordBad     = |diff;
    assign searchMatch = (dataW == prbsPredict(prev_q)) && (dataW != '0);
    assign sumW        = SW'(cnt_q) + SW'(errBits);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!chk_en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = SEARCH;
                SEARCH:  if (data_valid_i && seeded_q && searchMatch &&
                             match_q == MCW'(LOCK_CNT - 1)) state_d = LOCKED;
                LOCKED:  if (data_valid_i && wordBad &&
                             bad_q == BCW'(LOSS_THRESH - 1)) state_d = SEARCH;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next-state; the reference free-runs once locked so a corrupted word never re-seeds it.
    always_comb begin
        prev_d   = prev_q;
        ref_d    = ref_q;
        seeded_d = seeded_q;
        match_d  = match_q;
        bad_d    = bad_q;
        err_d    = 1'b0;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (!chk_en_i || state_q == IDLE) begin
            seeded_d = 1'b0;
            match_d  = '0;
            bad_d    = '0;
        end else if (data_valid_i && state_q == SEARCH) begin
            prev_d   = dataW;
            seeded_d = 1'b1;
            if (seeded_q) begin
                if (searchMatch) begin
                    match_d = match_q + MCW'(1);
                    if (match_q == MCW'(LOCK_CNT - 1)) begin
                        ref_d   = prbsPredict(dataW);
                        match_d = '0;
                        bad_d   = '0;
                    end
                end else begin
                    match_d = '0;
                end
            end
        end else if (data_valid_i && state_q == LOCKED) begin
            ref_d = prbsPredict(ref_q);
            if (wordBad) begin
                err_d    = 1'b1;
                sticky_d = 1'b1;
                cnt_d    = (sumW > SW'(CNT_MAX)) ? CNT_MAX : sumW[ERR_CNT_W-1:0];
                bad_d    = bad_q + BCW'(1);
                if (bad_q == BCW'(LOSS_THRESH - 1)) begin
                    bad_d    = '0;
                    match_d  = '0;
                    seeded_d = 1'b0;
                end
            end else begin
                bad_d = '0;
            end
        end
        if (clear_i) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            prev_q   <= '0;
            ref_q    <= '1;
            seeded_q <= 1'b0;
            match_q  <= '0;
            bad_q    <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            prev_q   <= prev_d;
            ref_q    <= ref_d;
            seeded_q <= seeded_d;
            match_q  <= match_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        lock_o       = (state_q == LOCKED);
        err_o        = err_q;
        err_sticky_o = sticky_q;
        err_cnt_o    = cnt_q;
    end

endmodule

// File: tb/tb_prbs_checker_parallel_fab.sv
`timescale 1ns/1ps
// Directed bench for prbs_checker_parallel_fab: a serial PRBS7 generator supplies words, expectations
// are queued when each word is driven and compared once the DUTs have sampled it.
module tb_prbs_checker_parallel_fab;

    typedef struct {
        string       tag;
        logic        lock;
        logic        err;
        logic [15:0] cnt;
        logic        sticky;
        logic [3:0]  cntS;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic        chk_en_i;
    logic        clear_i;
    logic        data_valid_i;
    logic [7:0]  data_i;
    logic        lock_o, err_o, err_sticky_o;
    logic [15:0] err_cnt_o;
    logic        lockS, errS, stickyS;
    logic [3:0]  cntS;

    int          total;
    int          bad;
    int          eCnt;
    int          eCntS;
    logic        eLock;
    logic        eSticky;
    logic [6:0]  h;
    logic [7:0]  w;
    exp_t        sb[$];

    always #5 clk_i = ~clk_i;

    prbs_checker_parallel_fab dut (
        .clk_i        (clk_i),
        .resetn_i     (resetn_i),
        .chk_en_i     (chk_en_i),
        .clear_i      (clear_i),
        .data_valid_i (data_valid_i),
        .data_i       (data_i),
        .lock_o       (lock_o),
        .err_o        (err_o),
        .err_sticky_o (err_sticky_o),
        .err_cnt_o    (err_cnt_o)
    );

    prbs_checker_parallel_fab #(.ERR_CNT_W(4)) dutS (
        .clk_i        (clk_i),
        .resetn_i     (resetn_i),
        .chk_en_i     (chk_en_i),
        .clear_i      (clear_i),
        .data_valid_i (data_valid_i),
        .data_i       (data_i),
        .lock_o       (lockS),
        .err_o        (errS),
        .err_sticky_o (stickyS),
        .err_cnt_o    (cntS)
    );

    // Serial x^7+x^6+1 generator, MSB of each word transmitted first.
    task automatic nextWord(output logic [7:0] word);
        logic nb;
        word = '0;
        for (int b = 0; b < 8; b++) begin
            nb   = h[6] ^ h[5];
            h    = {h[5:0], nb};
            word = {word[6:0], nb};
        end
    endtask

    function automatic int pop8(input logic [7:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int addSat(input int a, input int b, input int mx);
        return (a + b > mx) ? mx : a + b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboardEmpty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".lock"},    32'(lock_o),       32'(e.lock));
            check({e.tag, ".err"},     32'(err_o),        32'(e.err));
            check({e.tag, ".cnt"},     32'(err_cnt_o),    32'(e.cnt));
            check({e.tag, ".sticky"},  32'(err_sticky_o), 32'(e.sticky));
            check({e.tag, ".cntSat"},  32'(cntS),         32'(e.cntS));
        end
    endtask

    task automatic checkReset(input string tag);
        check({tag, ".lock"},   32'(lock_o),       32'd0);
        check({tag, ".err"},    32'(err_o),        32'd0);
        check({tag, ".cnt"},    32'(err_cnt_o),    32'd0);
        check({tag, ".sticky"}, 32'(err_sticky_o), 32'd0);
        check({tag, ".cntSat"}, 32'(cntS),         32'd0);
        check({tag, ".lockSat"}, 32'(lockS),       32'd0);
    endtask

    task automatic applyStimulus(input string tag, input logic en, input logic valid,
                                 input logic [7:0] data, input logic clr, input logic eErr);
        exp_t e;
        @(negedge clk_i);
        chk_en_i     = en;
        data_valid_i = valid;
        data_i       = data;
        clear_i      = clr;
        e.tag    = tag;
        e.lock   = eLock;
        e.err    = eErr;
        e.cnt    = 16'(eCnt);
        e.sticky = eSticky;
        e.cntS   = 4'(eCntS);
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        checkOutput();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total = 0; bad = 0;
        eLock = 0; eCnt = 0; eCntS = 0; eSticky = 0;
        resetn_i = 0; chk_en_i = 0; clear_i = 0; data_valid_i = 0; data_i = '0;
        h = 7'h7F;
        repeat (2) @(posedge clk_i);
        #1;
        checkReset("reset");
        @(negedge clk_i);
        resetn_i = 1;
        applyStimulus("enable", 1, 0, 8'h00, 0, 0);

        // Acquire lock: seed plus 16 matching words
        h = 7'h7F;
        applyStimulus("seed", 1, 1, 8'hFF, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            nextWord(w);
            if (k == 16) eLock = 1;
            applyStimulus("lockA", 1, 1, w, 0, 0);
        end

        // Single bit error while locked
        nextWord(w);
        eCnt = 1; eCntS = 1; eSticky = 1;
        applyStimulus("bit3", 1, 1, w ^ 8'h08, 0, 1);
        for (int k = 0; k < 3; k++) begin
            nextWord(w);
            applyStimulus("cleanB", 1, 1, w, 0, 0);
        end
        applyStimulus("gapL", 1, 0, 8'h5A, 0, 0);

        // Four all-zero words force loss of lock
        for (int k = 1; k <= 4; k++) begin
            nextWord(w);
            eCnt  = eCnt + pop8(w);
            eCntS = addSat(eCntS, pop8(w), 15);
            if (k == 4) eLock = 0;
            applyStimulus("zero", 1, 1, 8'h00, 0, 1);
        end
        for (int k = 1; k <= 18; k++) begin
            nextWord(w);
            if (k == 17) eLock = 1;
            applyStimulus("relock", 1, 1, w, 0, 0);
        end

        // Disable drops lock, counters retained; then clear
        eLock = 0;
        applyStimulus("disable", 0, 0, 8'h00, 0, 0);
        eCnt = 0; eCntS = 0; eSticky = 0;
        applyStimulus("clear", 0, 0, 8'h00, 1, 0);
        applyStimulus("enable2", 1, 0, 8'h00, 0, 0);
        for (int k = 0; k < 100; k++) begin
            applyStimulus("constA5", 1, 1, 8'hA5, 0, 0);
        end

        h = 7'h7F;
        applyStimulus("seed2", 1, 1, 8'hFF, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            nextWord(w);
            if (k == 16) eLock = 1;
            applyStimulus("lockC", 1, 1, w, 0, 0);
        end

        // Saturation of the narrow counter and clear racing an error
        for (int k = 0; k < 3; k++) begin
            nextWord(w);
            eCnt  = eCnt + 8;
            eCntS = addSat(eCntS, 8, 15);
            eSticky = 1;
            applyStimulus("sat", 1, 1, ~w, 0, 1);
        end
        nextWord(w);
        applyStimulus("satClean", 1, 1, w, 0, 0);
        nextWord(w);
        eCnt = 0; eCntS = 0; eSticky = 0;
        applyStimulus("clrErr", 1, 1, ~w, 1, 1);
        nextWord(w);
        applyStimulus("postClr", 1, 1, w, 0, 0);
        nextWord(w);
        eCnt = 5; eCntS = 5; eSticky = 1;
        applyStimulus("five", 1, 1, w ^ 8'h1F, 0, 1);
        applyStimulus("gapR1", 1, 0, 8'h33, 0, 0);
        applyStimulus("gapR2", 1, 0, 8'h00, 0, 0);

        // Asynchronous reset between clock edges
        @(negedge clk_i);
        #2;
        resetn_i = 0;
        #1;
        checkReset("asyncReset");
        @(negedge clk_i);
        resetn_i = 1;
        eLock = 0; eCnt = 0; eCntS = 0; eSticky = 0;
        applyStimulus("enable3", 1, 0, 8'h00, 0, 0);

        // Valid gaps during search keep the match count
        h = 7'h7F;
        applyStimulus("seed3", 1, 1, 8'hFF, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            nextWord(w);
            if (k == 16) eLock = 1;
            applyStimulus("gapLock", 1, 1, w, 0, 0);
            if (k % 4 == 0) applyStimulus("gapS", 1, 0, 8'hC3, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
